// File: rtl/ovl_fire_scheduler_if.sv
// ovl_fire_scheduler_if: report-record valid/ready channel from the fire scheduler to the logging sink
//   rpt_valid/rpt_id/rpt_xz/rpt_lost driven by master, rpt_ready driven by slave
interface ovl_fire_scheduler_if #(parameter int ID_WIDTH = 3);
  logic                rpt_valid;
  logic                rpt_ready;
  logic [ID_WIDTH-1:0] rpt_id;
  logic                rpt_xz;
  logic                rpt_lost;
  modport master (output rpt_valid, rpt_id, rpt_xz, rpt_lost, input rpt_ready);
  modport slave  (input rpt_valid, rpt_id, rpt_xz, rpt_lost, output rpt_ready);
endinterface

// File: rtl/ovl_fire_scheduler.sv
// ovl_fire_scheduler: latches OVL checker fires as pending events and serialises them round-robin as report records
//   clk, reset       rising-edge clock, synchronous active-high reset
//   enable           0 ignores all fire inputs (pending events still drain)
//   ignore_mask      per-checker fire suppression
//   fire, fire_xz    per-checker fire pulse and its X/Z qualifier
//   rpt              report record channel (master side)
//   pending          per-checker pending status
//   fire_count       saturating count of accepted fires
module ovl_fire_scheduler #(
  parameter int NUM_CHECKERS = 8,
  parameter int ID_WIDTH     = 3,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [NUM_CHECKERS-1:0] ignore_mask,
  input  logic [NUM_CHECKERS-1:0] fire,
  input  logic [NUM_CHECKERS-1:0] fire_xz,
  ovl_fire_scheduler_if.master    rpt,
  output logic [NUM_CHECKERS-1:0] pending,
  output logic [CNT_WIDTH-1:0]    fire_count
);
  localparam int N = NUM_CHECKERS;
  localparam logic [ID_WIDTH:0] NW = (ID_WIDTH+1)'(N);
  typedef enum logic {IDLE, PRESENT} state_t;
  state_t state, state_n;
  logic [N-1:0] acc, xz, lost, keep, clr, rot;
  logic [ID_WIDTH-1:0] ptr, off, win, id_q;
  logic [ID_WIDTH:0] wsum, nsum;
  logic [CNT_WIDTH:0] pop, sum;
  logic load, xz_q, lost_q;
  assign rpt.rpt_valid = (state == PRESENT);
  assign rpt.rpt_id    = id_q;
  assign rpt.rpt_xz    = xz_q;
  assign rpt.rpt_lost  = lost_q;
  // Winner search: rotate pending so the pointer sits at bit 0, take the lowest set
  // bit as an offset, then add the pointer back modulo N.
  always_comb begin
    acc = {N{enable}} & ~ignore_mask & fire;
    rot = N'({pending, pending} >> ptr);
    off = '0;
    for (int k = N-1; k >= 0; k--) off = rot[k] ? ID_WIDTH'(k) : off;
    wsum = {1'b0, ptr} + {1'b0, off};
    win = (wsum >= NW) ? ID_WIDTH'(wsum - NW) : wsum[ID_WIDTH-1:0];
    nsum = {1'b0, win} + (ID_WIDTH+1)'(1);
    load = |pending & ((state == IDLE) | rpt.rpt_ready);
    state_n = load ? PRESENT : (rpt.rpt_ready ? IDLE : state);
    clr = load ? (N'(1) << win) : '0;
    keep = pending & ~clr;
    pop = '0;
    for (int i = 0; i < N; i++) pop = pop + (CNT_WIDTH+1)'(acc[i]);
    sum = {1'b0, fire_count} + pop;
  end
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end
  // A fire landing on a checker being granted this edge starts a fresh event,
  // since keep already excludes the granted bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending    <= '0;
      xz         <= '0;
      lost       <= '0;
      ptr        <= '0;
      id_q       <= '0;
      xz_q       <= 1'b0;
      lost_q     <= 1'b0;
      fire_count <= '0;
    end else begin
      pending    <= keep | acc;
      xz         <= (keep & xz) | (acc & fire_xz);
      lost       <= keep & (lost | acc);
      fire_count <= sum[CNT_WIDTH] ? '1 : sum[CNT_WIDTH-1:0];
      if (load) begin
        id_q   <= win;
        xz_q   <= xz[win];
        lost_q <= lost[win];
        ptr    <= (nsum == NW) ? '0 : nsum[ID_WIDTH-1:0];
      end
    end
  end
endmodule

// File: tb/tb_ovl_fire_scheduler.sv
// tb_ovl_fire_scheduler: directed checks of the OVL fire scheduler
module tb_ovl_fire_scheduler;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic [7:0]  ignore_mask = '0;
  logic [7:0]  fire = '0;
  logic [7:0]  fire_xz = '0;
  logic [7:0]  pending;
  logic [15:0] fire_count;
  int tests = 0;
  int fails = 0;
  ovl_fire_scheduler_if #(.ID_WIDTH(3)) rpt ();
  ovl_fire_scheduler #(.NUM_CHECKERS(8), .ID_WIDTH(3), .CNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .enable(enable), .ignore_mask(ignore_mask),
    .fire(fire), .fire_xz(fire_xz), .rpt(rpt), .pending(pending), .fire_count(fire_count));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask
  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask
  initial begin
    rpt.rpt_ready = 1'b0;
    do_reset();
    chk("rst_valid", 32'(rpt.rpt_valid), 0);
    chk("rst_pending", 32'(pending), 0);
    chk("rst_count", 32'(fire_count), 0);
    chk("rst_id", 32'(rpt.rpt_id), 0);
    // single fire on checker 2
    rpt.rpt_ready = 1'b1;
    fire = 8'h04;
    tick();
    fire = 8'h00;
    chk("t1_pending", 32'(pending), 32'h04);
    chk("t1_valid_early", 32'(rpt.rpt_valid), 0);
    tick();
    chk("t1_valid", 32'(rpt.rpt_valid), 1);
    chk("t1_id", 32'(rpt.rpt_id), 2);
    chk("t1_xz", 32'(rpt.rpt_xz), 0);
    chk("t1_lost", 32'(rpt.rpt_lost), 0);
    chk("t1_count", 32'(fire_count), 1);
    tick();
    chk("t1_idle", 32'(rpt.rpt_valid), 0);
    // all eight fire at once
    do_reset();
    fire = 8'hFF;
    tick();
    fire = 8'h00;
    chk("t2_count", 32'(fire_count), 8);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk($sformatf("t2_valid%0d", k), 32'(rpt.rpt_valid), 1);
      chk($sformatf("t2_id%0d", k), 32'(rpt.rpt_id), 32'(k));
    end
    tick();
    chk("t2_idle", 32'(rpt.rpt_valid), 0);
    // back-pressure merges repeats of checker 5 behind a stalled record of checker 0
    rpt.rpt_ready = 1'b0;
    fire = 8'h01;
    tick();
    fire = 8'h00;
    tick();
    fire = 8'h20;
    tick();
    fire_xz = 8'h20;
    tick();
    fire_xz = 8'h00;
    tick();
    fire = 8'h00;
    chk("t3_stall_id", 32'(rpt.rpt_id), 0);
    chk("t3_pending", 32'(pending), 32'h20);
    chk("t3_count", 32'(fire_count), 12);
    rpt.rpt_ready = 1'b1;
    tick();
    chk("t3_valid", 32'(rpt.rpt_valid), 1);
    chk("t3_id", 32'(rpt.rpt_id), 5);
    chk("t3_xz", 32'(rpt.rpt_xz), 1);
    chk("t3_lost", 32'(rpt.rpt_lost), 1);
    tick();
    chk("t3_idle", 32'(rpt.rpt_valid), 0);
    // round-robin fairness between checkers 1 and 6
    do_reset();
    fire = 8'h42;
    tick();
    for (int k = 0; k < 8; k++) begin
      tick();
      chk($sformatf("t4_valid%0d", k), 32'(rpt.rpt_valid), 1);
      chk($sformatf("t4_id%0d", k), 32'(rpt.rpt_id), (k % 2 == 1) ? 6 : 1);
    end
    fire = 8'h00;
    repeat (4) tick();
    chk("t4_drain_valid", 32'(rpt.rpt_valid), 0);
    chk("t4_drain_pending", 32'(pending), 0);
    chk("t4_count", 32'(fire_count), 18);
    // ignore_mask and enable
    ignore_mask = 8'h10;
    fire = 8'h10;
    tick();
    chk("t5_mask_pending", 32'(pending), 0);
    chk("t5_mask_count", 32'(fire_count), 18);
    ignore_mask = 8'h00;
    enable = 1'b0;
    fire = 8'h01;
    tick();
    fire = 8'h00;
    chk("t5_en_pending", 32'(pending), 0);
    chk("t5_en_count", 32'(fire_count), 18);
    tick();
    chk("t5_valid", 32'(rpt.rpt_valid), 0);
    enable = 1'b1;
    // reset while a record is presented with three pending behind it
    rpt.rpt_ready = 1'b0;
    fire = 8'h0F;
    tick();
    fire = 8'h00;
    tick();
    chk("t6_valid_pre", 32'(rpt.rpt_valid), 1);
    chk("t6_npend_pre", 32'($countones(pending)), 3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_valid", 32'(rpt.rpt_valid), 0);
    chk("t6_pending", 32'(pending), 0);
    chk("t6_count", 32'(fire_count), 0);
    // counter saturation
    rpt.rpt_ready = 1'b1;
    fire = 8'hFF;
    repeat (8191) tick();
    chk("t6_count_bulk", 32'(fire_count), 65528);
    fire = 8'h3F;
    tick();
    chk("t6_count_fffe", 32'(fire_count), 32'hFFFE);
    fire = 8'h03;
    tick();
    chk("t6_count_sat", 32'(fire_count), 32'hFFFF);
    fire = 8'h81;
    tick();
    chk("t6_count_hold", 32'(fire_count), 32'hFFFF);
    fire = 8'h00;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
